// File: rtl/fsic_io_serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsic_io_serdes_pkg
// Purpose  : Shared definitions for the FSIC IO SERDES transmit lane: state
//            encoding, default word geometry, PRBS7 idle-fill constants and
//            the single-step LFSR helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fsic_io_serdes_pkg;

  // Transmit state machine encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  // Default word geometry.
  localparam int CLK_RATIO = 4;
  localparam int IDLE_WORD = 0;

  // PRBS7, x^7 + x^6 + 1: feedback from bits 6 and 5, shifted in at bit 0.
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'h60;

  // One LFSR step; the new bit lands in bit 0 and is also the output bit.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsic_io_serdes_tx_prbs7.sv
`default_nettype none
// ============================================================================
// Module   : fsic_io_serdes_tx_prbs7
// Purpose  : PRBS7 idle-fill generator. Presents the next WIDTH PRBS bits as
//            a word (first generated bit in bit 0) and advances by WIDTH
//            steps when 'advance' is high.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset (LFSR returns to seed)
//            advance  - consume the presented word
//            word     - next WIDTH PRBS bits, LSB first
// Revision : 1.0 - initial release
// ============================================================================
module fsic_io_serdes_tx_prbs7
  import fsic_io_serdes_pkg::*;
#(
  parameter int WIDTH = CLK_RATIO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [WIDTH-1:0] word
);

  logic [6:0] lfsr;
  logic [6:0] lfsr_adv;

  // Unroll WIDTH steps so a whole idle word is available in one cycle.
  always_comb begin
    lfsr_adv = lfsr;
    word     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lfsr_adv = prbs7_step(lfsr_adv);
      word[i]  = lfsr_adv[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PRBS7_SEED;
    end else if (advance) begin
      lfsr <= lfsr_adv;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsic_io_serdes_tx.sv
`default_nettype none
// ============================================================================
// Module   : fsic_io_serdes_tx
// Purpose  : FSIC IO SERDES lane transmitter. Buffers one parallel word
//            behind a valid/ready handshake and serialises words LSB first,
//            one bit per ioclk, with no gaps between words. When no word is
//            pending at a word boundary an idle word is inserted so the
//            receiver's word phase stays aligned.
// Ports    : ioclk            - serial bit clock (posedge)
//            axis_rst_n       - asynchronous active-low reset
//            txen             - lane transmit enable
//            txdata_in        - parallel word, bit 0 sent first
//            txdata_in_valid  - txdata_in holds a word
//            txdata_in_ready  - holding register accepts the word this cycle
//            Serial_Data_out  - registered serial bit
//            txclk_en         - registered, high while bits are driven
//            tx_underrun      - one-cycle pulse when an idle word is loaded
//                               while streaming
// Config   : `define FSIC_IO_SERDES_TX_PRBS_EN to use a PRBS7 idle fill
//            instead of pIDLE_WORD.
// Revision : 1.0 - initial release
// ============================================================================
module fsic_io_serdes_tx
  import fsic_io_serdes_pkg::*;
#(
  parameter int                    pCLK_RATIO = CLK_RATIO,
  parameter logic [pCLK_RATIO-1:0] pIDLE_WORD = pCLK_RATIO'(IDLE_WORD)
) (
  input  logic                  ioclk,
  input  logic                  axis_rst_n,
  input  logic                  txen,
  input  logic [pCLK_RATIO-1:0] txdata_in,
  input  logic                  txdata_in_valid,
  output logic                  txdata_in_ready,
  output logic                  Serial_Data_out,
  output logic                  txclk_en,
  output logic                  tx_underrun
);

  localparam int             PW      = $clog2(pCLK_RATIO);
  localparam logic [PW-1:0] PH_LAST = PW'(pCLK_RATIO - 1);

  tx_state_t             state;
  logic [PW-1:0]         phase;
  logic [pCLK_RATIO-1:0] shift_reg;
  logic [pCLK_RATIO-1:0] hold_word;
  logic                  hold_valid;

  logic [pCLK_RATIO-1:0] idle_fill;
  logic [pCLK_RATIO-1:0] next_word;
  logic                  phase_last;
  logic                  load_now;
  logic                  accept;

  // A new word enters the shift register on the edge that leaves IDLE and on
  // every last-bit edge where the lane stays enabled.
  always_comb begin
    phase_last      = (phase == PH_LAST);
    load_now        = txen && ((state == ST_IDLE) ||
                               (((state == ST_RUN) || (state == ST_DRAIN)) && phase_last));
    txdata_in_ready = !hold_valid || load_now;
    accept          = txdata_in_valid && txdata_in_ready;
    // The shift register always takes the old hold word; a word accepted on
    // the same edge goes to hold, giving a fixed one-word buffer delay.
    next_word       = hold_valid ? hold_word : idle_fill;
  end

`ifdef FSIC_IO_SERDES_TX_PRBS_EN
  logic idle_insert;
  assign idle_insert = load_now && !hold_valid;

  fsic_io_serdes_tx_prbs7 #(
    .WIDTH (pCLK_RATIO)
  ) u_prbs7 (
    .clk     (ioclk),
    .rst_n   (axis_rst_n),
    .advance (idle_insert),
    .word    (idle_fill)
  );
`else
  assign idle_fill = pIDLE_WORD;
`endif

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state           <= ST_IDLE;
      phase           <= '0;
      shift_reg       <= '0;
      hold_word       <= '0;
      hold_valid      <= 1'b0;
      Serial_Data_out <= 1'b0;
      txclk_en        <= 1'b0;
      tx_underrun     <= 1'b0;
    end else begin
      // Holding register: accepting refills it, a load alone empties it.
      if (accept) begin
        hold_word  <= txdata_in;
        hold_valid <= 1'b1;
      end else if (load_now) begin
        hold_valid <= 1'b0;
      end

      // Only a load while actively streaming counts as an underrun; the
      // first load out of IDLE and a re-enable out of DRAIN do not.
      tx_underrun <= load_now && !hold_valid && (state == ST_RUN);

      case (state)
        ST_IDLE: begin
          Serial_Data_out <= 1'b0;
          txclk_en        <= 1'b0;
          if (txen) begin
            state     <= ST_RUN;
            phase     <= '0;
            shift_reg <= next_word;
          end
        end

        ST_RUN, ST_DRAIN: begin
          Serial_Data_out <= shift_reg[0];
          txclk_en        <= 1'b1;
          if (phase_last) begin
            phase <= '0;
            if (txen) begin
              state     <= ST_RUN;
              shift_reg <= next_word;
            end else begin
              // Word finished with the lane disabled: stop at the boundary.
              state <= ST_IDLE;
            end
          end else begin
            phase     <= phase + 1'b1;
            shift_reg <= shift_reg >> 1;
            state     <= txen ? ST_RUN : ST_DRAIN;
          end
        end

        default: begin
          state           <= ST_IDLE;
          phase           <= '0;
          Serial_Data_out <= 1'b0;
          txclk_en        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsic_io_serdes_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fsic_io_serdes_tx
// Purpose  : Self-checking bench for fsic_io_serdes_tx (pCLK_RATIO=4).
//            A word/bit-queue model predicts every output each cycle; a few
//            directed sequences pin hand-computed bit streams, then random
//            traffic with enable toggling and occasional resets follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsic_io_serdes_tx;

  localparam int R = 4;

  logic         ioclk;
  logic         axis_rst_n;
  logic         txen;
  logic [R-1:0] txdata_in;
  logic         txdata_in_valid;
  logic         txdata_in_ready;
  logic         Serial_Data_out;
  logic         txclk_en;
  logic         tx_underrun;

  int checks = 0;
  int errors = 0;

`ifdef FSIC_IO_SERDES_TX_PRBS_EN
  localparam logic [7:0] IDLE8 = 8'h40;  // PRBS7 from all-ones: 0,0,0,0,0,0,1,0
`else
  localparam logic [7:0] IDLE8 = 8'h00;
`endif

  fsic_io_serdes_tx #(
    .pCLK_RATIO (R),
    .pIDLE_WORD (4'h0)
  ) dut (
    .ioclk           (ioclk),
    .axis_rst_n      (axis_rst_n),
    .txen            (txen),
    .txdata_in       (txdata_in),
    .txdata_in_valid (txdata_in_valid),
    .txdata_in_ready (txdata_in_ready),
    .Serial_Data_out (Serial_Data_out),
    .txclk_en        (txclk_en),
    .tx_underrun     (tx_underrun)
  );

  initial ioclk = 1'b0;
  always #5 ioclk = ~ioclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ioclk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: a one-entry hold queue, a queue of bits still to be
  // put on the line for the current word, and a PRBS bit history.
  // ---------------------------------------------------------------------
  logic [R-1:0] hold_q[$];
  bit           line_q[$];
  bit           started;     // a word is on the line (not idle)
  bit           last_txen;   // txen seen at the previous edge
  logic         exp_ser, exp_en, exp_urun;
`ifdef FSIC_IO_SERDES_TX_PRBS_EN
  bit           prbs_hist[$];  // oldest first, seven entries
`endif

  function automatic logic [R-1:0] next_idle();
    logic [R-1:0] w;
    w = '0;
`ifdef FSIC_IO_SERDES_TX_PRBS_EN
    for (int i = 0; i < R; i++) begin
      bit b;
      b = prbs_hist[0] ^ prbs_hist[1];   // b[n] = b[n-7] ^ b[n-6]
      prbs_hist.push_back(b);
      void'(prbs_hist.pop_front());
      w[i] = b;
    end
`endif
    return w;
  endfunction

  task automatic model_reset();
    hold_q.delete();
    line_q.delete();
    started   = 0;
    last_txen = 0;
    exp_ser   = 0;
    exp_en    = 0;
    exp_urun  = 0;
`ifdef FSIC_IO_SERDES_TX_PRBS_EN
    prbs_hist.delete();
    repeat (7) prbs_hist.push_back(1'b1);
`endif
  endtask

  function automatic bit model_ready();
    return (hold_q.size() == 0) || (txen && (!started || line_q.size() == 1));
  endfunction

  always @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      model_reset();
    end else begin
      bit load, acc;
      logic [R-1:0] w;
      load     = txen && (!started || line_q.size() == 1);
      acc      = txdata_in_valid && model_ready();
      exp_urun = load && started && last_txen && (hold_q.size() == 0);
      if (started) begin
        exp_ser = line_q.pop_front();
        exp_en  = 1;
      end else begin
        exp_ser = 0;
        exp_en  = 0;
      end
      if (load) begin
        if (hold_q.size() != 0) w = hold_q.pop_front();
        else                    w = next_idle();
        for (int i = 0; i < R; i++) line_q.push_back(w[i]);
        started = 1;
      end else if (line_q.size() == 0) begin
        started = 0;
      end
      last_txen = txen;
      if (acc) hold_q.push_back(txdata_in);
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge ioclk) begin
    chk("cyc_serial",   Serial_Data_out, exp_ser);
    chk("cyc_txclk_en", txclk_en,        exp_en);
    chk("cyc_underrun", tx_underrun,     exp_urun);
    chk("cyc_ready",    txdata_in_ready, model_ready());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [15:0] cap16;
    logic [7:0]  cap8;
    logic [3:0]  cap4;
    int          upulses;
    logic        rdy;

    axis_rst_n      = 1'b0;
    txen            = 1'b0;
    txdata_in_valid = 1'b0;
    txdata_in       = '0;
    repeat (3) tick();
    chk("reset_serial",   Serial_Data_out, 0);
    chk("reset_txclk_en", txclk_en,        0);
    chk("reset_underrun", tx_underrun,     0);
    chk("reset_ready",    txdata_in_ready, 1);
    axis_rst_n = 1'b1;
    tick();

    // Word A parked in hold, then back-to-back 3, C, F.
    txdata_in_valid = 1'b1;
    txdata_in       = 4'hA;
    #1 chk("idle_ready", txdata_in_ready, 1);
    tick();
    txen      = 1'b1;
    txdata_in = 4'h3;
    #1 chk("ready_on_first_load", txdata_in_ready, 1);
    tick();
    txdata_in = 4'hC;
    #1 chk("ready_low_hold_full", txdata_in_ready, 0);
    chk("txclk_en_before_first_bit", txclk_en, 0);
    for (int k = 3; k <= 18; k++) begin
      tick();
      cap16[k-3] = Serial_Data_out;
      if (k == 3) chk("txclk_en_with_first_bit", txclk_en, 1);
      if (k == 4) chk("ready_mid_word", txdata_in_ready, 0);
      if (k == 5) chk("ready_on_boundary", txdata_in_ready, 1);
      if (k == 6) txdata_in = 4'hF;
      if (k == 10) txdata_in_valid = 1'b0;
    end
    chk("stream_A_3_C_F", cap16, 16'hFC3A);
    chk("underrun_after_stream", tx_underrun, 1);

    // Word 9 drained after txen drops at phase 1; held word 5 goes next.
    txdata_in_valid = 1'b1;
    txdata_in       = 4'h9;
    tick();
    txdata_in = 4'h5;
    repeat (3) tick();
    txdata_in_valid = 1'b0;
    tick();
    cap4[0] = Serial_Data_out;
    txen    = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      cap4[k] = Serial_Data_out;
      if (k == 2) chk("ready_drain_hold_full", txdata_in_ready, 0);
    end
    chk("drain_word_9", cap4, 4'h9);
    tick();
    chk("drain_idle_serial", Serial_Data_out, 0);
    chk("drain_idle_txclk_en", txclk_en, 0);
    tick();
    txen = 1'b1;
    tick();
    chk("reenable_load_no_en", txclk_en, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      cap4[k] = Serial_Data_out;
    end
    chk("held_word_5_first", cap4, 4'h5);
    chk("underrun_after_word_5", tx_underrun, 1);

    // Reset at phase 2 with word 6 in hold.
    txdata_in_valid = 1'b1;
    txdata_in       = 4'h6;
    tick();
    txdata_in_valid = 1'b0;
    tick();
    chk("txclk_en_before_reset", txclk_en, 1);
    axis_rst_n = 1'b0;
    txen       = 1'b0;
    #1;
    chk("async_reset_serial",   Serial_Data_out, 0);
    chk("async_reset_txclk_en", txclk_en,        0);
    chk("async_reset_underrun", tx_underrun,     0);
    chk("async_reset_ready",    txdata_in_ready, 1);
    repeat (2) tick();
    axis_rst_n = 1'b1;
    tick();
    txen = 1'b1;
    tick();
    chk("no_underrun_first_load", tx_underrun, 0);
    upulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cap8[k] = Serial_Data_out;
      if (k < 7) upulses += int'(tx_underrun);
      if (k == 3) chk("underrun_second_boundary", tx_underrun, 1);
    end
    chk("idle_fill_8_bits", cap8, IDLE8);
    chk("underrun_pulse_count", upulses, 1);

    // Random traffic with enable toggling and rare resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge ioclk);
      rdy = txdata_in_ready;
      @(posedge ioclk);
      #1;
      if (!txdata_in_valid || rdy) begin
        txdata_in_valid = ($urandom_range(0, 99) < 60);
        txdata_in       = R'($urandom);
      end
      if ($urandom_range(0, 99) < 8) txen = !txen;
      axis_rst_n = ($urandom_range(0, 999) >= 3);
    end
    axis_rst_n = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsic_io_serdes_tx.md
Name: fsic_io_serdes_tx

Overview:
- Transmit-side serializer for the FSIC IO SERDES lane; the counterpart of the lane receiver.
- Accepts pCLK_RATIO-bit parallel words from the core side through a valid/ready handshake and buffers one word.
- Shifts each word out LSB-first on Serial_Data_out, one bit per ioclk, and produces txclk_en to gate the forwarded lane clock.
- Streams continuously while enabled: when no data is pending it inserts an idle word, so the receiver's free-running word phase stays aligned.

Parameters:
- pCLK_RATIO, 4, bits per word; serial bits per core word. Must be ≥2.
- pIDLE_WORD, 0, word transmitted when the holding register is empty at a word boundary.

Ports:
- ioclk  input  1  serial bit clock; all logic on posedge.
- axis_rst_n  input  1  asynchronous active-low reset.
- txen  input  1  lane transmit enable; synchronous to ioclk.
- txdata_in  input  pCLK_RATIO  parallel word to send; bit 0 is sent first.
- txdata_in_valid  input  1  txdata_in holds a word.
- txdata_in_ready  output  1  the holding register accepts the word this cycle.
- Serial_Data_out  output  1  registered serial bit.
- txclk_en  output  1  registered; high while bits are being driven.
- tx_underrun  output  1  one-cycle registered pulse when an idle word is loaded while in RUN.

Behaviour:
- Clock and reset: one clock, ioclk, posedge only. Reset is asynchronous active-low axis_rst_n. While reset is low all outputs and state are 0: state=IDLE, phase=0, shift_reg=0, hold_valid=0.
- States:
  - IDLE: Serial_Data_out=0, txclk_en=0.
  - RUN: shifting continuously.
  - DRAIN: finishing the current word after txen drops.
- load_now = (IDLE && txen) || ((RUN || DRAIN) && phase==pCLK_RATIO-1 && next state is RUN).
- IDLE→RUN edge (txen sampled 1): shift_reg <= hold word if hold_valid, else pIDLE_WORD. Phase <= 0; hold_valid is consumed.
- Each RUN/DRAIN edge:
  - Serial_Data_out <= shift_reg[0]; txclk_en <= 1.
  - If phase==pCLK_RATIO-1: phase <= 0 and shift_reg <= next word, where next word is the hold word or pIDLE_WORD.
  - Otherwise: shift_reg <= shift_reg>>1 and phase <= phase+1.
- Latency: from the edge that samples txen=1, bit0 of the first word is on Serial_Data_out after the next edge, i.e. 2 edges. Thereafter each word occupies exactly pCLK_RATIO cycles with no gaps.
- RUN with txen=0: go to DRAIN. Remaining bits of the current word are still sent. At phase==pCLK_RATIO-1, no new word is loaded and the state goes to IDLE. On the following edge Serial_Data_out <= 0 and txclk_en <= 0. The hold register is retained.
- txen re-asserted during DRAIN: return to RUN. The word boundary is unchanged; no bits are dropped.
- Handshake:
  - txdata_in_ready = !hold_valid || load_now (combinational).
  - Transfer occurs when valid && ready.
  - A simultaneous load and accept is allowed: the shift register takes the old hold word and hold takes the new one.
  - When hold is empty and a word is accepted on a load edge, that word goes to hold, not into the shift register. This gives a fixed one-word buffering.
  - txdata_in must stay stable while valid && !ready.
- tx_underrun: pulses when load_now occurs in RUN with hold_valid=0. It does not pulse for the first load out of IDLE.
- Phase counter width is $clog2(pCLK_RATIO); it wraps explicitly at pCLK_RATIO-1.
- Reset mid-word: the word is aborted, the hold word is discarded, and outputs go to 0 immediately.

Optional Feature:
- Macro: FSIC_IO_SERDES_TX_PRBS_EN.
- When defined: the idle fill is a PRBS7 sequence (x^7+x^6+1, seed 7'h7F) instead of pIDLE_WORD.
  - The LFSR advances pCLK_RATIO steps per inserted idle word and its bits are sent LSB-first.
  - The LFSR resets to the seed on axis_rst_n and holds its value in IDLE.
- When undefined: no LFSR is present and the idle fill is pIDLE_WORD.

Decomposition:
- Shared package fsic_io_serdes_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - default constants CLK_RATIO=4 and IDLE_WORD=0;
  - the PRBS7 seed and taps.
- One natural sub-module: fsic_io_serdes_tx_prbs7 (LFSR that outputs a pCLK_RATIO-bit word and has an advance input), instantiated only under the macro.

Test Plan (pCLK_RATIO=4):
- Reset, then txen=1 with word 4'hA valid → ready=1; bits 0,1,0,1 on consecutive cycles starting 2 edges after txen is sampled; txclk_en rises with the first bit.
- Back-to-back 4'h3, 4'hC, 4'hF held valid → stream 1100 0011 1111 with no gap; ready is high only on load edges once hold is full.
- txen=1 with no valid data for 8 cycles → Serial_Data_out=0 for 8 cycles; tx_underrun pulses once at the second word boundary.
- txen dropped at phase 1 of word 4'h9 → remaining bits 0,1 are sent, then IDLE; txclk_en=0 and Serial_Data_out=0; a pending hold word is sent first after txen=1.
- axis_rst_n asserted at phase 2 → all outputs 0 asynchronously; hold is cleared; after release the first word sent is the next accepted one.
- With FSIC_IO_SERDES_TX_PRBS_EN and no data → the first 8 idle bits match the PRBS7 reference from seed 7'h7F.
